// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Purpose:
//   Cleans up a bouncing mechanical switch. The raw pin is first brought into
//   the clk domain through a SYNC_STAGES-deep flop chain. A four-state FSM with
//   a saturating-at-terminal counter then only accepts a new level once the
//   synchronized input has held it for DEBOUNCE_CYCLES consecutive clocks.
//   The accepted level, its edge pulses and a push-on/push-off toggle are all
//   registered outputs.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive clocks a new level must persist (2..2^24)
//   SYNC_STAGES     : synchronizer depth (2..4)
//
// Ports:
//   clk       in   single clock, all state on its rising edge
//   rst       in   asynchronous, active-high reset
//   sw_raw    in   raw switch pin, asynchronous to clk
//   sw        out  debounced level
//   sw_rise   out  one-cycle pulse on the first cycle sw is 1 after being 0
//   sw_fall   out  one-cycle pulse on the first cycle sw is 0 after being 1
//   sw_toggle out  level that inverts on every sw_rise
//
// Latency: a clean change on sw_raw appears on sw exactly
// SYNC_STAGES + DEBOUNCE_CYCLES rising edges after the first edge that samples
// the new level.
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_raw,
  output logic sw,
  output logic sw_rise,
  output logic sw_fall,
  output logic sw_toggle
);

  // Wide enough to hold DEBOUNCE_CYCLES itself, so the terminal value
  // DEBOUNCE_CYCLES-1 always fits without wrap.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW       = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_chain_q;
  logic [SYNC_STAGES-1:0] sync_chain_d;
  logic                   sync_q;

  // Stage 0 captures the pin; every later stage copies its predecessor.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      assign sync_chain_d[gi] = sw_raw;
    end else begin : g_rest
      assign sync_chain_d[gi] = sync_chain_q[gi-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain_q <= '0;
    end else begin
      sync_chain_q <= sync_chain_d;
    end
  end

  // Only the last stage is allowed into the debounce logic; earlier stages
  // may still be metastable.
  assign sync_q = sync_chain_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic sw_q,        sw_d;
  logic sw_rise_q,   sw_rise_d;
  logic sw_fall_q,   sw_fall_d;
  logic sw_toggle_q, sw_toggle_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      LOW: begin
        // First sample of the new level already counts as one.
        if (sync_q) begin
          cnt_d   = CNT_ONE;
          state_d = WAIT_HIGH;
        end
      end

      WAIT_HIGH: begin
        if (!sync_q) begin
          // Bounced back: abandon this attempt, output untouched.
          cnt_d   = CNT_ZERO;
          state_d = LOW;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = HIGH;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      HIGH: begin
        if (!sync_q) begin
          cnt_d   = CNT_ONE;
          state_d = WAIT_LOW;
        end
      end

      WAIT_LOW: begin
        if (sync_q) begin
          cnt_d   = CNT_ZERO;
          state_d = HIGH;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          state_d = LOW;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end

      default: begin
        cnt_d   = CNT_ZERO;
        state_d = LOW;
      end
    endcase
  end

  // Outputs are decoded from the *next* state so that sw, its pulses and the
  // toggle all update on the same edge that commits the state transition.
  always_comb begin
    sw_d        = (state_d == HIGH) || (state_d == WAIT_LOW);
    sw_rise_d   = sw_d & ~sw_q;
    sw_fall_d   = ~sw_d & sw_q;
    sw_toggle_d = sw_toggle_q ^ sw_rise_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOW;
      cnt_q       <= CNT_ZERO;
      sw_q        <= 1'b0;
      sw_rise_q   <= 1'b0;
      sw_fall_q   <= 1'b0;
      sw_toggle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sw_q        <= sw_d;
      sw_rise_q   <= sw_rise_d;
      sw_fall_q   <= sw_fall_d;
      sw_toggle_q <= sw_toggle_d;
    end
  end

  assign sw        = sw_q;
  assign sw_rise   = sw_rise_q;
  assign sw_fall   = sw_fall_q;
  assign sw_toggle = sw_toggle_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
//
// Directed scenarios (clean press, bounce, glitch, press/release/press, reset
// mid-count, reset mid-pulse, high at reset release) followed by randomized
// held levels. The reference model keeps a sliding history of sampled raw
// values: the synchronizer is a pure SYNC-edge delay, and sw flips as soon as
// the last DEB delayed samples all disagree with the current sw.
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int HW   = SYNC + DEB;

  logic clk = 1'b0;
  logic rst;
  logic sw_raw;
  logic sw, sw_rise, sw_fall, sw_toggle;

  switch_debouncer #(
    .DEBOUNCE_CYCLES(DEB),
    .SYNC_STAGES    (SYNC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_raw   (sw_raw),
    .sw       (sw),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .sw_toggle(sw_toggle)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_step = 0;

  // Reference model state
  logic [HW-1:0] hist;     // bit 0 = raw value sampled at the latest edge
  logic exp_sw, exp_rise, exp_fall, exp_tog;

  // Per-scenario observations
  int rise_seen, fall_seen;
  int ev_q[$];             // 1 = rise, 2 = fall, in order seen

  task check_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (step %0d)", tag, obs, exp, n_step);
    end
  endtask

  task check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task model_reset();
    hist     = '0;
    exp_sw   = 1'b0;
    exp_rise = 1'b0;
    exp_fall = 1'b0;
    exp_tog  = 1'b0;
  endtask

  task model_edge(input logic raw);
    logic prev;
    hist = {hist[HW-2:0], raw};
    prev = exp_sw;
    // Window = what the debouncer has seen through the synchronizer delay.
    if (hist[SYNC +: DEB] == {DEB{~exp_sw}}) exp_sw = ~exp_sw;
    exp_rise = exp_sw & ~prev;
    exp_fall = ~exp_sw & prev;
    if (exp_rise) exp_tog = ~exp_tog;
  endtask

  task clear_obs();
    rise_seen = 0;
    fall_seen = 0;
    ev_q.delete();
  endtask

  // One clock with sw_raw = raw, then compare all outputs 1 time unit later.
  task step(input logic raw);
    sw_raw = raw;
    @(posedge clk);
    #1;
    n_step++;
    model_edge(raw);
    if (sw_rise === 1'b1) begin rise_seen++; ev_q.push_back(1); end
    if (sw_fall === 1'b1) begin fall_seen++; ev_q.push_back(2); end
    $display("step %0d raw=%b sw=%b rise=%b fall=%b tog=%b (exp %b%b%b%b)",
             n_step, raw, sw, sw_rise, sw_fall, sw_toggle,
             exp_sw, exp_rise, exp_fall, exp_tog);
    check_bit("sw",         sw,        exp_sw);
    check_bit("sw_rise",    sw_rise,   exp_rise);
    check_bit("sw_fall",    sw_fall,   exp_fall);
    check_bit("sw_toggle",  sw_toggle, exp_tog);
    check_bit("pulse_excl", sw_rise & sw_fall, 1'b0);
  endtask

  task steps(input logic raw, input int n);
    for (int i = 0; i < n; i++) step(raw);
  endtask

  task check_zero(input string tag);
    check_bit({tag, "_sw"},   sw,        1'b0);
    check_bit({tag, "_rise"}, sw_rise,   1'b0);
    check_bit({tag, "_fall"}, sw_fall,   1'b0);
    check_bit({tag, "_tog"},  sw_toggle, 1'b0);
  endtask

  // Assert reset at the current (off-edge) time, verify the asynchronous
  // clear, hold it over two edges, release it away from any edge.
  task pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    $display("reset asserted (%s)", tag);
    check_zero({tag, "_async"});
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_zero({tag, "_held"});
    end
    rst = 1'b0;
  endtask

  initial begin
    logic lvl;
    int   len;

    // High at reset release: sw_raw already 1 while in reset.
    rst    = 1'b1;
    sw_raw = 1'b1;
    model_reset();
    #1;
    check_zero("por");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_zero("por_held");
    end
    rst = 1'b0;
    clear_obs();
    steps(1'b1, 5);
    check_bit("rel_high_early", sw, 1'b0);
    step(1'b1);
    check_bit("rel_high_6th", sw, 1'b1);
    steps(1'b1, 4);
    check_int("rel_high_rises", rise_seen, 1);

    // Clean release, then clean press from a quiet low.
    steps(1'b0, 10);
    clear_obs();
    steps(1'b1, 6);
    check_bit("clean_6th_sw", sw, 1'b1);
    check_bit("clean_6th_rise", sw_rise, 1'b1);
    steps(1'b1, 4);
    check_int("clean_rises", rise_seen, 1);
    steps(1'b0, 10);

    // Bounce: 1,0,1,1,0 then steady 1.
    clear_obs();
    step(1'b1); step(1'b0); step(1'b1); step(1'b1); step(1'b0);
    steps(1'b1, 5);
    check_bit("bounce_early", sw, 1'b0);
    step(1'b1);
    check_bit("bounce_6th", sw, 1'b1);
    steps(1'b1, 5);
    check_int("bounce_rises", rise_seen, 1);
    steps(1'b0, 10);

    // Glitch: three clocks high while sw=0.
    clear_obs();
    steps(1'b1, 3);
    steps(1'b0, 10);
    check_int("glitch_rises", rise_seen, 0);
    check_int("glitch_falls", fall_seen, 0);

    // Press / release / press.
    clear_obs();
    steps(1'b1, 10);
    steps(1'b0, 10);
    steps(1'b1, 10);
    check_int("prp_events", ev_q.size(), 3);
    if (ev_q.size() == 3) begin
      check_int("prp_ev0", ev_q[0], 1);
      check_int("prp_ev1", ev_q[1], 2);
      check_int("prp_ev2", ev_q[2], 1);
    end

    // Reset mid-count: sw low, toggle high, counter part-way (cnt=2).
    steps(1'b0, 10);
    steps(1'b1, 4);
    #3;
    pulse_reset("midcount");
    clear_obs();
    steps(1'b1, 5);
    check_bit("midcount_early", sw, 1'b0);
    step(1'b1);
    check_bit("midcount_6th", sw, 1'b1);
    check_int("midcount_rises", rise_seen, 1);

    // Reset mid-pulse: truncate a live sw_rise.
    steps(1'b0, 10);
    steps(1'b1, 6);
    check_bit("midpulse_rise_live", sw_rise, 1'b1);
    sw_raw = 1'b0;
    #2;
    pulse_reset("midpulse");
    steps(1'b0, 3);

    // Randomized held levels.
    for (int s = 0; s < 80; s++) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 7);
      steps(lvl, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
